// File: rtl/la_step_checker.sv
// la_step_checker
//   Logic-analyzer driven step checker. The management SoC places two
//   operands, an expected product and a step id on the LA bus, then raises
//   a strobe. The block multiplies the operands serially (one multiplier bit
//   per cycle, LSB first) and compares the product with the expected value.
//   Step id and pass/fail status are driven on mprj_io for the chip-level
//   LA testbench.
//
//   Handshake: a step is accepted on the rising edge of the qualified strobe
//   (la_data_in[102] with la_oenb[102]==0) while IDLE. busy rises the cycle
//   after acceptance and falls when the report (status + product + counters)
//   is final. A rising strobe edge while busy is dropped and recorded in the
//   sticky overrun flag. A qualified abort (bit 103) while busy ends the step
//   with status 11 and no counter/product update.
//
// Ports
//   wb_clk_i     in   1    clock
//   wb_rst_i     in   1    synchronous active-high reset
//   la_data_in   in   128  [15:0]=A [47:32]=B [95:64]=expected [101:96]=id
//                          [102]=strobe [103]=abort
//   la_oenb      in   128  LA bit is a valid input only when its oenb bit is 0
//   la_data_out  out  128  [31:0]=product [39:32]=pass_cnt [47:40]=fail_cnt
//                          [48]=busy [49]=overrun, rest 0
//   io_out       out  38   [25:20]=step id [37:36]=status, rest 0
//   io_oeb       out  38   0 on 37:36 and 25:20, 1 elsewhere
//
// Status codes: 00 pass/idle, 01 busy, 10 fail, 11 aborted.

module la_step_checker #(
  parameter int MUL_W = 16,
  parameter int CNT_W = 8
) (
  input  logic         wb_clk_i,
  input  logic         wb_rst_i,
  input  logic [127:0] la_data_in,
  input  logic [127:0] la_oenb,
  output logic [127:0] la_data_out,
  output logic [37:0]  io_out,
  output logic [37:0]  io_oeb
);

  localparam int PW    = 2 * MUL_W;
  localparam int IDX_W = (MUL_W > 1) ? $clog2(MUL_W) : 1;

  localparam logic [1:0] ST_PASS  = 2'b00;
  localparam logic [1:0] ST_BUSY  = 2'b01;
  localparam logic [1:0] ST_FAIL  = 2'b10;
  localparam logic [1:0] ST_ABORT = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_CHECK = 2'd2
  } state_t;

  state_t            state;
  logic              strb_q;
  logic [MUL_W-1:0]  a_r;
  logic [MUL_W-1:0]  b_r;
  logic [PW-1:0]     exp_r;
  logic [5:0]        step_r;
  logic [1:0]        status_r;
  logic [PW-1:0]     acc;
  logic [IDX_W-1:0]  idx;
  logic [PW-1:0]     product;
  logic [CNT_W-1:0]  pass_cnt;
  logic [CNT_W-1:0]  fail_cnt;
  logic              busy;
  logic              overrun;

  logic              strb;
  logic              abrt;
  logic              cap;
  logic [PW-1:0]     addend;
  logic              unused_bits;

  assign strb = la_data_in[102] & ~la_oenb[102];
  assign abrt = la_data_in[103] & ~la_oenb[103];
  assign cap  = strb & ~strb_q;

  // Partial product for the current multiplier bit.
  assign addend = b_r[idx] ? ({{MUL_W{1'b0}}, a_r} << idx) : '0;

  // Only a subset of the LA bus is meaningful; fold the rest away.
  assign unused_bits = ^{la_data_in, la_oenb};

  always_ff @(posedge wb_clk_i) begin
    // strb_q follows the strobe even through reset, so a strobe that is
    // held high across a reset does not look like a fresh edge afterwards.
    strb_q <= strb;
    if (wb_rst_i) begin
      state    <= S_IDLE;
      a_r      <= '0;
      b_r      <= '0;
      exp_r    <= '0;
      step_r   <= '0;
      status_r <= ST_PASS;
      acc      <= '0;
      idx      <= '0;
      product  <= '0;
      pass_cnt <= '0;
      fail_cnt <= '0;
      busy     <= 1'b0;
      overrun  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          // A capture edge beats a simultaneous abort here.
          if (cap) begin
            a_r      <= la_data_in[MUL_W-1:0];
            b_r      <= la_data_in[32 +: MUL_W];
            exp_r    <= la_data_in[64 +: PW];
            step_r   <= la_data_in[101:96];
            status_r <= ST_BUSY;
            busy     <= 1'b1;
            acc      <= '0;
            idx      <= '0;
            state    <= S_RUN;
          end
        end
        S_RUN: begin
          if (cap) overrun <= 1'b1;
          if (abrt) begin
            status_r <= ST_ABORT;
            busy     <= 1'b0;
            state    <= S_IDLE;
          end else begin
            acc <= acc + addend;
            idx <= idx + 1'b1;
            if (idx == IDX_W'(MUL_W - 1)) state <= S_CHECK;
          end
        end
        S_CHECK: begin
          if (cap) overrun <= 1'b1;
          if (abrt) begin
            status_r <= ST_ABORT;
            busy     <= 1'b0;
            state    <= S_IDLE;
          end else begin
            product <= acc;
            if (acc == exp_r) begin
              status_r <= ST_PASS;
              if (pass_cnt != '1) pass_cnt <= pass_cnt + 1'b1;
            end else begin
              status_r <= ST_FAIL;
              if (fail_cnt != '1) fail_cnt <= fail_cnt + 1'b1;
            end
            busy  <= 1'b0;
            state <= S_IDLE;
          end
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    la_data_out               = '0;
    la_data_out[PW-1:0]       = product;
    la_data_out[32 +: CNT_W]  = pass_cnt;
    la_data_out[40 +: CNT_W]  = fail_cnt;
    la_data_out[48]           = busy;
    la_data_out[49]           = overrun;
  end

  always_comb begin
    io_out        = '0;
    io_out[25:20] = step_r;
    io_out[37:36] = status_r;
  end

  always_comb begin
    io_oeb        = '1;
    io_oeb[25:20] = '0;
    io_oeb[37:36] = '0;
  end

endmodule
